// File: rtl/ocp_req_scheduler_if.sv
// Bridge-side bundle for the OCP request scheduler: PCIe write/read request channels,
// completion return, OCP master command/data/response signals and error reporting.
interface ocp_req_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10,
  parameter int TAG_W  = 8
);
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_resp_en;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [TAG_W-1:0]  rd_tag;

  logic              cpl_valid;
  logic              cpl_ready;
  logic [DATA_W-1:0] cpl_data;
  logic [TAG_W-1:0]  cpl_tag;
  logic              cpl_last;
  logic [1:0]        cpl_status;

  logic [ADDR_W-1:0] mst_address;
  logic [LEN_W-1:0]  mst_burst_length;
  logic [2:0]        mst_burst_seq;
  logic              mst_write_request;
  logic              mst_read_request;
  logic [DATA_W-1:0] mst_write_data;
  logic              mst_data_valid;
  logic              mst_data_last;
  logic              mst_cmd_accept;
  logic              mst_data_accept;
  logic [1:0]        mst_resp;
  logic [DATA_W-1:0] mst_read_data;
  logic              mst_resp_accept;

  logic              err_valid;
  logic [1:0]        err_code;
  logic [TAG_W-1:0]  err_tag;
  logic              busy;

  modport master (
    input  wr_req_valid, wr_addr, wr_len, wr_resp_en, wr_data_valid, wr_data,
    input  rd_req_valid, rd_addr, rd_len, rd_tag, cpl_ready,
    input  mst_cmd_accept, mst_data_accept, mst_resp, mst_read_data,
    output wr_req_ready, wr_data_ready, rd_req_ready,
    output cpl_valid, cpl_data, cpl_tag, cpl_last, cpl_status,
    output mst_address, mst_burst_length, mst_burst_seq, mst_write_request, mst_read_request,
    output mst_write_data, mst_data_valid, mst_data_last, mst_resp_accept,
    output err_valid, err_code, err_tag, busy
  );

  modport slave (
    output wr_req_valid, wr_addr, wr_len, wr_resp_en, wr_data_valid, wr_data,
    output rd_req_valid, rd_addr, rd_len, rd_tag, cpl_ready,
    output mst_cmd_accept, mst_data_accept, mst_resp, mst_read_data,
    input  wr_req_ready, wr_data_ready, rd_req_ready,
    input  cpl_valid, cpl_data, cpl_tag, cpl_last, cpl_status,
    input  mst_address, mst_burst_length, mst_burst_seq, mst_write_request, mst_read_request,
    input  mst_write_data, mst_data_valid, mst_data_last, mst_resp_accept,
    input  err_valid, err_code, err_tag, busy
  );
endinterface

// File: rtl/ocp_req_scheduler.sv
// Write-first (bounded streak) scheduler feeding the OCP master one transaction at a time; grant -> request next cycle.
// Backpressure: data/completion readies mirror OCP accepts / cpl_ready; stalls beyond TIMEOUT abort with an error pulse.
module ocp_req_scheduler #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LEN_W         = 10,
  parameter int TAG_W         = 8,
  parameter int MAX_WR_STREAK = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  ocp_req_scheduler_if.master bus
);
  localparam int STRK_W = $clog2(MAX_WR_STREAK + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_WR_STREAK);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [1:0] R_NULL = 2'b00, R_DVA = 2'b01, R_FAIL = 2'b10, R_ERR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WR_XFER, S_WR_RESP, S_RD_CMD, S_RD_RESP} state_e;

  state_e              state_q, state_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [LEN_W-1:0]    beat_q, beat_d, len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TAG_W-1:0]    tag_q, tag_d, err_tag_q, err_tag_d;
  logic                resp_en_q, resp_en_d, cmd_done_q, cmd_done_d, err_vld_q, err_vld_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                wr_win, rd_win, progress, data_act, last_beat, beat_fire, cmd_fire, cpl_fire;

  function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    to_d       = to_q;
    beat_d     = beat_q;
    len_d      = len_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    resp_en_d  = resp_en_q;
    cmd_done_d = cmd_done_q;
    err_vld_d  = 1'b0;
    err_code_d = 2'b00;
    err_tag_d  = '0;
    wr_win     = 1'b0;
    rd_win     = 1'b0;
    progress   = 1'b0;
    beat_fire  = 1'b0;
    cmd_fire   = 1'b0;
    cpl_fire   = 1'b0;
    data_act   = (beat_q != len_q);
    last_beat  = (beat_q == len_q - LEN_W'(1));

    bus.wr_req_ready      = 1'b0;
    bus.rd_req_ready      = 1'b0;
    bus.wr_data_ready     = 1'b0;
    bus.mst_write_request = 1'b0;
    bus.mst_read_request  = 1'b0;
    bus.mst_write_data    = {DATA_W{1'b0}};
    bus.mst_data_valid    = 1'b0;
    bus.mst_data_last     = 1'b0;
    bus.mst_resp_accept   = 1'b0;
    bus.cpl_valid         = 1'b0;
    bus.cpl_data          = {DATA_W{1'b0}};
    bus.cpl_tag           = '0;
    bus.cpl_last          = 1'b0;
    bus.cpl_status        = 2'b00;

    case (state_q)
      S_IDLE: begin
        wr_win = bus.wr_req_valid && (!bus.rd_req_valid || (streak_q < STRK_MAX));
        rd_win = bus.rd_req_valid && !wr_win;
        bus.wr_req_ready = wr_win;
        bus.rd_req_ready = rd_win;
        to_d       = '0;
        beat_d     = '0;
        cmd_done_d = 1'b0;
        if (wr_win) begin
          state_d   = S_WR_XFER;
          addr_d    = bus.wr_addr;
          len_d     = len_eff(bus.wr_len);
          tag_d     = '0;
          resp_en_d = bus.wr_resp_en;
          if (!bus.rd_req_valid)      streak_d = '0;
          else if (streak_q != STRK_MAX) streak_d = streak_q + STRK_W'(1);
        end else if (rd_win) begin
          state_d   = S_RD_CMD;
          addr_d    = bus.rd_addr;
          len_d     = len_eff(bus.rd_len);
          tag_d     = bus.rd_tag;
          resp_en_d = 1'b0;
          streak_d  = '0;
        end
      end
      S_WR_XFER: begin
        // Command and data phases run independently; leave only when both are finished.
        bus.mst_write_request = !cmd_done_q;
        bus.mst_data_valid    = data_act && bus.wr_data_valid;
        bus.mst_write_data    = bus.wr_data;
        bus.mst_data_last     = data_act && last_beat;
        bus.wr_data_ready     = data_act && bus.mst_data_accept;
        cmd_fire  = !cmd_done_q && bus.mst_cmd_accept;
        beat_fire = data_act && bus.wr_data_valid && bus.mst_data_accept;
        progress  = cmd_fire || beat_fire;
        if (cmd_fire)  cmd_done_d = 1'b1;
        if (beat_fire) beat_d = beat_q + LEN_W'(1);
        if ((cmd_done_q || bus.mst_cmd_accept) && (!data_act || (beat_fire && last_beat)))
          state_d = resp_en_q ? S_WR_RESP : S_IDLE;
      end
      S_WR_RESP: begin
        bus.mst_resp_accept = 1'b1;
        progress = (bus.mst_resp != R_NULL);
        if (bus.mst_resp == R_DVA) begin
          state_d = S_IDLE;
        end else if (bus.mst_resp != R_NULL) begin
          state_d    = S_IDLE;
          err_vld_d  = 1'b1;
          err_code_d = (bus.mst_resp == R_FAIL) ? 2'b01 : 2'b10;
          err_tag_d  = tag_q;
        end
      end
      S_RD_CMD: begin
        bus.mst_read_request = 1'b1;
        if (bus.mst_cmd_accept) begin
          progress = 1'b1;
          beat_d   = '0;
          state_d  = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        bus.cpl_valid       = (bus.mst_resp != R_NULL);
        bus.cpl_data        = bus.mst_read_data;
        bus.cpl_status      = bus.mst_resp;
        bus.cpl_tag         = tag_q;
        bus.cpl_last        = bus.cpl_valid && last_beat;
        bus.mst_resp_accept = bus.cpl_ready;
        cpl_fire = bus.cpl_valid && bus.cpl_ready;
        progress = cpl_fire;
        if (cpl_fire) begin
          beat_d = beat_q + LEN_W'(1);
          if (bus.mst_resp == R_FAIL || bus.mst_resp == R_ERR) begin
            err_vld_d  = 1'b1;
            err_code_d = (bus.mst_resp == R_FAIL) ? 2'b01 : 2'b10;
            err_tag_d  = tag_q;
          end
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stall watchdog: any handshake restarts the count; expiry abandons the transaction.
    if (state_q != S_IDLE) begin
      if (progress) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        to_d       = '0;
        state_d    = S_IDLE;
        err_vld_d  = 1'b1;
        err_code_d = 2'b11;
        err_tag_d  = tag_q;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      streak_q   <= '0;
      to_q       <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      resp_en_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= 2'b00;
      err_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      to_q       <= to_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      resp_en_q  <= resp_en_d;
      cmd_done_q <= cmd_done_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
      err_tag_q  <= err_tag_d;
    end
  end

  assign bus.mst_address      = addr_q;
  assign bus.mst_burst_length = len_q;
  assign bus.mst_burst_seq    = 3'b000;
  assign bus.err_valid        = err_vld_q;
  assign bus.err_code         = err_code_q;
  assign bus.err_tag          = err_tag_q;
  assign bus.busy             = (state_q != S_IDLE);

endmodule
